// File: rtl/sprite_pixel_fetch.sv
// sprite_pixel_fetch
//   Read side of a square palette-index sprite array. Each cycle one VGA draw
//   coordinate (DrawX/DrawY) is looked up against the sprite position and the
//   sprite array. Two cycles later the result appears on out_*. The result
//   carries the palette index with opacity (out_hit) and mirroring applied.
//   The block also counts the opaque pixels drawn in each frame, for use by
//   the collision logic.
//
// Ports
//   Clk, Reset_n      clock; synchronous active-low reset
//   frame_start       1-cycle pulse; loads the sprite shadow registers and
//                     publishes the finished frame's hit count
//   spr_x, spr_y      sprite top-left corner (shadowed at frame_start)
//   spr_en            sprite visible (shadowed at frame_start)
//   flip_h, flip_v    horizontal / vertical mirror (shadowed at frame_start)
//   sprite_rgb        palette-index array, indexed [row][col]
//   pix_valid         DrawX/DrawY valid this cycle
//   DrawX, DrawY      current pixel coordinate
//   out_valid         pix_valid delayed by two cycles
//   out_hit           pixel is inside an enabled sprite and is not transparent
//   out_idx           palette index, or TRANSP when out_hit is low
//   out_x, out_y      coordinate aligned with out_*
//   frame_hits        opaque-pixel count of the previous frame
module sprite_pixel_fetch #(
  parameter int SIZE   = 40,
  parameter int IDX_W  = 5,
  parameter int TRANSP = 0,
  parameter int CNT_W  = 11
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              frame_start,
  input  logic [9:0]        spr_x,
  input  logic [9:0]        spr_y,
  input  logic              spr_en,
  input  logic              flip_h,
  input  logic              flip_v,
  input  logic [IDX_W-1:0]  sprite_rgb [0:SIZE-1][0:SIZE-1],
  input  logic              pix_valid,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  output logic              out_valid,
  output logic              out_hit,
  output logic [IDX_W-1:0]  out_idx,
  output logic [9:0]        out_x,
  output logic [9:0]        out_y,
  output logic [CNT_W-1:0]  frame_hits
);

  localparam int               AW      = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [AW-1:0]    LAST    = AW'(SIZE - 1);
  localparam logic [10:0]      SIZE_W  = 11'(SIZE);
  localparam logic [IDX_W-1:0] TR      = IDX_W'(TRANSP);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [9:0]       spr_x_s, spr_y_s;
  logic             en_s, fh_s, fv_s;

  logic [10:0]      dx, dy;
  logic             inside_c;
  logic [AW-1:0]    col_c, row_c;

  logic             s1_valid, s1_inside;
  logic [AW-1:0]    s1_row, s1_col;
  logic [9:0]       s1_x, s1_y;

  logic [IDX_W-1:0] idx_c;
  logic             hit_c;

  logic [CNT_W-1:0] cnt, cnt_inc;
  logic             retire;

  // Sprite position, enable and mirroring are only taken at frame_start.
  // A moving sprite therefore never tears mid-frame. A pixel presented in
  // the frame_start cycle still sees the old values.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      spr_x_s <= '0;
      spr_y_s <= '0;
      en_s    <= 1'b0;
      fh_s    <= 1'b0;
      fv_s    <= 1'b0;
    end else if (frame_start) begin
      spr_x_s <= spr_x;
      spr_y_s <= spr_y;
      en_s    <= spr_en;
      fh_s    <= flip_h;
      fv_s    <= flip_v;
    end
  end

  // Offsets are taken as 11-bit unsigned values. A pixel left of or above
  // the sprite borrows and wraps to a huge offset, so a single "< SIZE" test
  // covers both edges. A sprite hanging off the right or bottom of the screen
  // clips naturally, because DrawX never wraps back to column 0.
  // Row and column are forced to zero outside the sprite. The array read
  // index then always stays in range.
  always_comb begin
    dx       = {1'b0, DrawX} - {1'b0, spr_x_s};
    dy       = {1'b0, DrawY} - {1'b0, spr_y_s};
    inside_c = en_s & (dx < SIZE_W) & (dy < SIZE_W);
    col_c    = '0;
    row_c    = '0;
    if (inside_c) begin
      col_c = fh_s ? (LAST - dx[AW-1:0]) : dx[AW-1:0];
      row_c = fv_s ? (LAST - dy[AW-1:0]) : dy[AW-1:0];
    end
  end

  // Stage 1 registers the geometry result. An idle slot clears its inside
  // flag but keeps the last address and coordinate.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      s1_valid  <= 1'b0;
      s1_inside <= 1'b0;
      s1_row    <= '0;
      s1_col    <= '0;
      s1_x      <= '0;
      s1_y      <= '0;
    end else begin
      s1_valid <= pix_valid;
      if (pix_valid) begin
        s1_inside <= inside_c;
        s1_row    <= row_c;
        s1_col    <= col_c;
        s1_x      <= DrawX;
        s1_y      <= DrawY;
      end else begin
        s1_inside <= 1'b0;
      end
    end
  end

  // Array lookup and transparency test for the pixel held in stage 1.
  always_comb begin
    idx_c = s1_inside ? sprite_rgb[s1_row][s1_col] : TR;
    hit_c = s1_inside & (idx_c != TR);
  end

  // Stage 2 drives the outputs. Misses report TRANSP. An idle slot drops
  // out_hit and leaves index and coordinates at their last values.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      out_valid <= 1'b0;
      out_hit   <= 1'b0;
      out_idx   <= TR;
      out_x     <= '0;
      out_y     <= '0;
    end else begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_hit <= hit_c;
        out_idx <= hit_c ? idx_c : TR;
        out_x   <= s1_x;
        out_y   <= s1_y;
      end else begin
        out_hit <= 1'b0;
      end
    end
  end

  // Saturating next-count value, and whether a hit retires this cycle.
  always_comb begin
    retire  = out_valid & out_hit;
    cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
  end

  // Per-frame opaque pixel counter. A hit that retires in the frame_start
  // cycle still belongs to the finishing frame. It is folded into
  // frame_hits, and the new frame's count starts again from zero.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      cnt        <= '0;
      frame_hits <= '0;
    end else if (frame_start) begin
      frame_hits <= retire ? cnt_inc : cnt;
      cnt        <= '0;
    end else if (retire) begin
      cnt <= cnt_inc;
    end
  end

endmodule
